// File: rtl/ninjakun_hiscore_seq_if.sv
// Foreground-VRAM high-score port: the sequencer drives address/data/write and owns the mux
// through hs_access; the RAM side returns read data with one cycle of latency.
interface ninjakun_hiscore_seq_if;
    logic        hs_access;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_out;
    logic [7:0]  hs_data_in;
    logic        hs_write;

    modport master (
        output hs_access, hs_address, hs_data_out, hs_write,
        input  hs_data_in
    );

    modport slave (
        input  hs_access, hs_address, hs_data_out, hs_write,
        output hs_data_in
    );
endinterface

// File: rtl/ninjakun_hiscore_seq.sv
// Ninja-Kun high-score sequencer: halts the game CPUs, then copies the host-loaded score
// buffer into foreground VRAM (restore) or VRAM into the buffer (save), and releases the bus.
module ninjakun_hiscore_seq #(
    parameter logic [10:0] HS_BASE = 11'h000,
    parameter int unsigned HS_LEN  = 64,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                   ROMCL,
    input  logic                   RESET,
    input  logic [7:0]             dl_addr,
    input  logic                   dl_wr,
    input  logic [7:0]             dl_din,
    output logic [7:0]             dl_dout,
    input  logic                   restore_req,
    input  logic                   save_req,
    output logic                   pause_req,
    input  logic                   pause_ack,
    ninjakun_hiscore_seq_if.master hs,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StPause   = 3'd1;
    localparam logic [2:0] StGrab    = 3'd2;
    localparam logic [2:0] StXfer    = 3'd3;
    localparam logic [2:0] StDrain   = 3'd4;
    localparam logic [2:0] StRelease = 3'd5;

    localparam int unsigned AW    = (HS_LEN > 1) ? $clog2(HS_LEN) : 1;
    localparam int unsigned Depth = 1 << AW;
    localparam int unsigned CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
    localparam logic [7:0]    IdxLast = 8'(HS_LEN - 1);

    logic [2:0]    state_q, state_d;
    logic          dir_save_q, dir_save_d;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    wdata_q;
    logic [7:0]    dl_dout_q;
    logic [7:0]    hs_buf_q [Depth];

    logic          buf_we;
    logic [AW-1:0] buf_wa;
    logic [7:0]    buf_wd;
    logic [7:0]    idx_m1;
    logic [10:0]   vaddr;
    logic          unused_dl_addr;

    assign idx_m1         = idx_q - 8'd1;
    assign vaddr          = HS_BASE + {3'b000, idx_q};
    assign unused_dl_addr = ^dl_addr;

    always_comb begin
        state_d    = state_q;
        dir_save_d = dir_save_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (restore_req || save_req) begin
                    dir_save_d = !restore_req;
                    idx_d      = 8'd0;
                    cnt_d      = '0;
                    state_d    = StPause;
                end
            end
            StPause: begin
                if (pause_ack) begin
                    state_d = StGrab;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGrab: state_d = StXfer;
            StXfer: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == IdxLast) state_d = StDrain;
            end
            StDrain: state_d = StRelease;
            StRelease: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Save data lags its address by one cycle, so byte i-1 lands while address i is out.
    always_comb begin
        buf_we = 1'b0;
        buf_wa = dl_addr[AW-1:0];
        buf_wd = dl_din;
        if (state_q == StIdle) begin
            buf_we = dl_wr;
        end else if (dir_save_q &&
                     ((state_q == StXfer && idx_q != 8'd0) || state_q == StDrain)) begin
            buf_we = 1'b1;
            buf_wa = idx_m1[AW-1:0];
            buf_wd = hs.hs_data_in;
        end
    end

    always_ff @(posedge ROMCL) begin
        if (!RESET && buf_we) hs_buf_q[buf_wa] <= buf_wd;
    end

    // wdata_q follows idx_d so the byte for the next write cycle is already registered.
    always_ff @(posedge ROMCL) begin
        if (RESET) begin
            state_q    <= StIdle;
            dir_save_q <= 1'b0;
            idx_q      <= 8'd0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= 8'd0;
            dl_dout_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            dir_save_q <= dir_save_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wdata_q    <= hs_buf_q[idx_d[AW-1:0]];
            dl_dout_q  <= hs_buf_q[dl_addr[AW-1:0]];
        end
    end

    assign busy           = (state_q != StIdle);
    assign pause_req      = busy;
    assign done           = done_q;
    assign err            = err_q;
    assign dl_dout        = dl_dout_q;
    assign hs.hs_access   = (state_q == StGrab) || (state_q == StXfer) || (state_q == StDrain);
    assign hs.hs_write    = (state_q == StXfer) && !dir_save_q;
    assign hs.hs_address  = hs.hs_access ? {5'b00000, vaddr} : 16'h0000;
    assign hs.hs_data_out = hs.hs_write ? wdata_q : 8'h00;
endmodule

// File: tb/tb_ninjakun_hiscore_seq.sv
// Bench for the high-score sequencer: two instances (plain and wrapping/short), a VRAM model
// per instance, and a buffer model checked against bus traces and host read-back.
module tb_ninjakun_hiscore_seq;
    localparam logic [10:0] BaseA = 11'h000;
    localparam int unsigned LenA  = 64;
    localparam int unsigned ToA   = 16;
    localparam logic [10:0] BaseB = 11'h7F0;
    localparam int unsigned LenB  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dl_addr [2];
    logic       dl_wr [2];
    logic [7:0] dl_din [2];
    logic [7:0] dl_dout [2];
    logic       restore_req [2];
    logic       save_req [2];
    logic       pause_req [2];
    logic       pause_ack [2];
    logic       busy [2];
    logic       done [2];
    logic       err [2];

    ninjakun_hiscore_seq_if hs_a ();
    ninjakun_hiscore_seq_if hs_b ();

    ninjakun_hiscore_seq #(.HS_BASE(BaseA), .HS_LEN(LenA), .TIMEOUT(ToA)) dut_a (
        .ROMCL(clk), .RESET(rst), .dl_addr(dl_addr[0]), .dl_wr(dl_wr[0]), .dl_din(dl_din[0]),
        .dl_dout(dl_dout[0]), .restore_req(restore_req[0]), .save_req(save_req[0]),
        .pause_req(pause_req[0]), .pause_ack(pause_ack[0]), .hs(hs_a), .busy(busy[0]),
        .done(done[0]), .err(err[0])
    );

    ninjakun_hiscore_seq #(.HS_BASE(BaseB), .HS_LEN(LenB)) dut_b (
        .ROMCL(clk), .RESET(rst), .dl_addr(dl_addr[1]), .dl_wr(dl_wr[1]), .dl_din(dl_din[1]),
        .dl_dout(dl_dout[1]), .restore_req(restore_req[1]), .save_req(save_req[1]),
        .pause_req(pause_req[1]), .pause_ack(pause_ack[1]), .hs(hs_b), .busy(busy[1]),
        .done(done[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    int          n_checks;
    int          n_pass;
    int          cyc;
    logic [7:0]  vram [2][2048];
    logic [7:0]  mbuf [2][256];
    logic [7:0]  pend_rd [2];
    logic        pend_we [2];
    logic [10:0] pend_wa [2];
    logic [7:0]  pend_wd [2];
    int n_wr [2], n_acc [2], n_busy [2], n_preq [2], n_done [2], n_err [2], bad_bus [2];
    int first_wr [2], last_wr [2], first_acc [2], last_acc [2];
    int first_busy [2], last_busy [2], done_cyc [2], err_cyc [2];
    logic [10:0] wr_addr_log [2][256];
    logic [7:0]  wr_data_log [2][256];

    function automatic logic [10:0] base_of(input int d);
        return (d == 0) ? BaseA : BaseB;
    endfunction

    function automatic int len_of(input int d);
        return (d == 0) ? LenA : LenB;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_log(input int d);
        n_wr[d] = 0; n_acc[d] = 0; n_busy[d] = 0; n_preq[d] = 0;
        n_done[d] = 0; n_err[d] = 0; bad_bus[d] = 0;
        first_wr[d] = -1; last_wr[d] = -1; first_acc[d] = -1; last_acc[d] = -1;
        first_busy[d] = -1; last_busy[d] = -1; done_cyc[d] = -1; err_cyc[d] = -1;
        for (int k = 0; k < 256; k++) begin
            wr_addr_log[d][k] = 'x;
            wr_data_log[d][k] = 'x;
        end
    endtask

    task automatic sample(input int d, input logic acc, input logic wr, input logic [15:0] addr,
                          input logic [7:0] dout, input logic preq, input logic bsy,
                          input logic dn, input logic er);
        if ((wr && !acc) || addr[15:11] != 5'd0) bad_bus[d]++;
        if (acc) begin
            n_acc[d]++;
            if (first_acc[d] < 0) first_acc[d] = cyc;
            last_acc[d] = cyc;
            pend_rd[d]  = vram[d][addr[10:0]];
        end
        if (wr) begin
            if (n_wr[d] < 256) begin
                wr_addr_log[d][n_wr[d]] = addr[10:0];
                wr_data_log[d][n_wr[d]] = dout;
            end
            n_wr[d]++;
            if (first_wr[d] < 0) first_wr[d] = cyc;
            last_wr[d] = cyc;
        end
        pend_we[d] = acc && wr;
        pend_wa[d] = addr[10:0];
        pend_wd[d] = dout;
        if (bsy) begin
            n_busy[d]++;
            if (first_busy[d] < 0) first_busy[d] = cyc;
            last_busy[d] = cyc;
        end
        if (preq) n_preq[d]++;
        if (dn) begin n_done[d]++; done_cyc[d] = cyc; end
        if (er) begin n_err[d]++; err_cyc[d] = cyc; end
    endtask

    // One clock: apply last cycle's VRAM action, then observe the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) if (pend_we[d]) vram[d][pend_wa[d]] = pend_wd[d];
        hs_a.hs_data_in = pend_rd[0];
        hs_b.hs_data_in = pend_rd[1];
        cyc++;
        sample(0, hs_a.hs_access, hs_a.hs_write, hs_a.hs_address, hs_a.hs_data_out,
               pause_req[0], busy[0], done[0], err[0]);
        sample(1, hs_b.hs_access, hs_b.hs_write, hs_b.hs_address, hs_b.hs_data_out,
               pause_req[1], busy[1], done[1], err[1]);
    endtask

    task automatic do_write(input int d, input int a, input logic [7:0] v);
        dl_addr[d] = 8'(a); dl_din[d] = v; dl_wr[d] = 1'b1;
        tick();
        dl_wr[d] = 1'b0;
        mbuf[d][a] = v;
    endtask

    task automatic read_check(input int d, input int a);
        dl_addr[d] = 8'(a);
        tick();
        check_eq($sformatf("d%0d dl_dout[%0d]", d, a), dl_dout[d], mbuf[d][a]);
    endtask

    task automatic run_op(input int d, input bit rs, input bit sv, input int ack_delay,
                          input int ack_hold, input int inj_k);
        int k;
        clear_log(d);
        restore_req[d] = rs; save_req[d] = sv;
        tick();
        restore_req[d] = 1'b0; save_req[d] = 1'b0;
        k = 0;
        while (busy[d] && k < 5000) begin
            if (k == ack_delay) pause_ack[d] = 1'b1;
            if (ack_hold > 0 && k == ack_delay + ack_hold) pause_ack[d] = 1'b0;
            if (k == inj_k) begin
                save_req[d] = 1'b1;
                dl_addr[d] = 8'd5; dl_din[d] = ~mbuf[d][5]; dl_wr[d] = 1'b1;
            end
            tick();
            save_req[d] = 1'b0; dl_wr[d] = 1'b0;
            k++;
        end
        pause_ack[d] = 1'b0;
        check_eq($sformatf("d%0d op terminates", d), busy[d], 0);
    endtask

    task automatic check_common(input int d, input int ack_delay);
        int n;
        n = len_of(d);
        check_eq($sformatf("d%0d access cycles", d), n_acc[d], n + 2);
        check_eq($sformatf("d%0d busy cycles", d), n_busy[d], n + 4 + ack_delay);
        check_eq($sformatf("d%0d pause_req cycles", d), n_preq[d], n_busy[d]);
        check_eq($sformatf("d%0d done count", d), n_done[d], 1);
        check_eq($sformatf("d%0d done timing", d), done_cyc[d], last_busy[d] + 1);
        check_eq($sformatf("d%0d err count", d), n_err[d], 0);
        check_eq($sformatf("d%0d bus sanity", d), bad_bus[d], 0);
    endtask

    task automatic check_restore(input int d, input int ack_delay);
        int n;
        logic [10:0] ea;
        n = len_of(d);
        check_eq($sformatf("d%0d write count", d), n_wr[d], n);
        for (int k = 0; k < n; k++) begin
            ea = base_of(d) + 11'(k);
            check_eq($sformatf("d%0d write %0d addr/data", d, k),
                     {wr_addr_log[d][k], wr_data_log[d][k]}, {ea, mbuf[d][k]});
        end
        check_eq($sformatf("d%0d writes contiguous", d), last_wr[d] - first_wr[d] + 1, n);
        check_eq($sformatf("d%0d leading guard", d), first_acc[d], first_wr[d] - 1);
        check_eq($sformatf("d%0d trailing guard", d), last_acc[d], last_wr[d] + 1);
        check_common(d, ack_delay);
    endtask

    task automatic check_save(input int d, input int ack_delay);
        logic [10:0] ea;
        check_eq($sformatf("d%0d save writes", d), n_wr[d], 0);
        check_common(d, ack_delay);
        for (int k = 0; k < len_of(d); k++) begin
            ea = base_of(d) + 11'(k);
            mbuf[d][k] = vram[d][ea];
        end
        for (int k = 0; k < len_of(d); k++) read_check(d, k);
    endtask

    initial begin
        int dly;
        n_checks = 0; n_pass = 0; cyc = 0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            dl_addr[d] = 8'd0; dl_wr[d] = 1'b0; dl_din[d] = 8'd0;
            restore_req[d] = 1'b0; save_req[d] = 1'b0; pause_ack[d] = 1'b0;
            pend_rd[d] = 8'd0; pend_we[d] = 1'b0; pend_wa[d] = 11'd0; pend_wd[d] = 8'd0;
            for (int a = 0; a < 2048; a++) vram[d][a] = 8'h00;
            for (int a = 0; a < 256; a++) mbuf[d][a] = 8'h00;
            clear_log(d);
        end
        hs_a.hs_data_in = 8'h00;
        hs_b.hs_data_in = 8'h00;

        repeat (3) tick();
        check_eq("d0 reset outputs", {dl_dout[0], pause_req[0], busy[0], done[0], err[0],
                 hs_a.hs_access, hs_a.hs_write, hs_a.hs_address, hs_a.hs_data_out}, 0);
        check_eq("d1 reset outputs", {dl_dout[1], pause_req[1], busy[1], done[1], err[1],
                 hs_b.hs_access, hs_b.hs_write, hs_b.hs_address, hs_b.hs_data_out}, 0);
        rst = 1'b0;
        tick();

        // Restore a ramp; ack drops again once the transfer is under way.
        for (int i = 0; i < 64; i++) do_write(0, i, 8'hA0 + 8'(i));
        run_op(0, 1'b1, 1'b0, 3, 3, -1);
        check_restore(0, 3);

        // Save from a patterned VRAM.
        for (int a = 0; a < 2048; a++) vram[0][a] = 8'h5A ^ 8'(a);
        run_op(0, 1'b0, 1'b1, 0, 0, -1);
        check_save(0, 0);

        // Wrapping base on the second instance, random data both ways.
        for (int i = 0; i < 32; i++) do_write(1, i, 8'($urandom));
        dly = $urandom_range(0, 4);
        run_op(1, 1'b1, 1'b0, dly, 0, -1);
        check_restore(1, dly);
        for (int a = 0; a < 2048; a++) vram[1][a] = 8'($urandom);
        dly = $urandom_range(0, 4);
        run_op(1, 1'b0, 1'b1, dly, 0, -1);
        check_save(1, dly);

        // Pause timeout.
        run_op(0, 1'b0, 1'b1, -1, 0, -1);
        check_eq("timeout err count", n_err[0], 1);
        check_eq("timeout err timing", err_cyc[0], first_busy[0] + ToA);
        check_eq("timeout busy cycles", n_busy[0], ToA);
        check_eq("timeout no access", n_acc[0], 0);
        check_eq("timeout no done", n_done[0], 0);

        // Simultaneous requests, then a save_req and dl_wr landing mid-transfer.
        for (int i = 0; i < 64; i++) do_write(0, i, 8'($urandom));
        run_op(0, 1'b1, 1'b1, 0, 0, -1);
        check_restore(0, 0);
        run_op(0, 1'b1, 1'b0, 1, 0, 12);
        check_restore(0, 1);
        clear_log(0);
        repeat (4) tick();
        check_eq("ignored save_req stays idle", n_busy[0], 0);
        read_check(0, 5);

        // Reset during the 10th write cycle; buffer must survive for the next restore.
        clear_log(0);
        restore_req[0] = 1'b1;
        tick();
        restore_req[0] = 1'b0;
        pause_ack[0] = 1'b1;
        for (int k = 0; k < 200 && n_wr[0] < 10; k++) tick();
        check_eq("reached 10th write", n_wr[0], 10);
        rst = 1'b1;
        tick();
        check_eq("reset mid-op bus", {hs_a.hs_access, hs_a.hs_write, pause_req[0], busy[0]}, 0);
        rst = 1'b0;
        pause_ack[0] = 1'b0;
        repeat (6) tick();
        check_eq("no done after reset", n_done[0], 0);
        check_eq("writes before reset", n_wr[0], 10);
        run_op(0, 1'b1, 1'b0, 2, 0, -1);
        check_restore(0, 2);

        for (int i = 0; i < 8; i++) read_check(1, $urandom_range(0, LenB - 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
